// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - Decode-to-Execute pipeline register with load-use hazard, WB bypass, flush and stall

module id_ex_stage #(
  parameter int W  = 16,
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_valid,
  input  logic [N-1:0]  d_src,
  input  logic [N-1:0]  d_dst,
  input  logic          d_use_src,
  input  logic          d_use_dst,
  input  logic [W-1:0]  d_rsrc,
  input  logic [W-1:0]  d_rdst,
  input  logic [N-1:0]  d_wa,
  input  logic          d_reg_write,
  input  logic          d_mem_read,
  input  logic [CW-1:0] d_ctrl,
  input  logic [W-1:0]  d_imm,
  input  logic          flush,
  input  logic          ex_stall,
  input  logic          wb_reg_write,
  input  logic [N-1:0]  wb_wa,
  input  logic [W-1:0]  wb_wd,
  output logic          hold_decode,
  output logic          e_valid,
  output logic [W-1:0]  e_rsrc,
  output logic [W-1:0]  e_rdst,
  output logic [N-1:0]  e_src,
  output logic [N-1:0]  e_dst,
  output logic [N-1:0]  e_wa,
  output logic          e_reg_write,
  output logic          e_mem_read,
  output logic [CW-1:0] e_ctrl,
  output logic [W-1:0]  e_imm,
  output logic [W-1:0]  stall_count
);

  typedef enum logic [0:0] {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t       state_q;
  state_t       state_d;
  logic         src_hit;
  logic         dst_hit;
  logic         hazard;
  logic         do_bubble;
  logic         do_advance;
  logic [W-1:0] fwd_rsrc;
  logic [W-1:0] fwd_rdst;

  // A load in EX whose result the decoding instruction needs; suppressed while a bubble is already in flight
  assign src_hit = d_use_src & (d_src == e_wa);
  assign dst_hit = d_use_dst & (d_dst == e_wa);
  assign hazard  = d_valid & e_valid & e_mem_read & e_reg_write &
                   (state_q == RUN) & (src_hit | dst_hit);

  // Same-cycle writeback wins over the stale regFile read
  assign fwd_rsrc = (wb_reg_write && (wb_wa == d_src)) ? wb_wd : d_rsrc;
  assign fwd_rdst = (wb_reg_write && (wb_wa == d_dst)) ? wb_wd : d_rdst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: flush > ex_stall > hazard > advance
  always_comb begin
    state_d = state_q;
    if (flush)          state_d = RUN;
    else if (ex_stall)  state_d = state_q;
    else if (hazard)    state_d = BUBBLE;
    else                state_d = RUN;
  end

  // Outputs and per-edge action decode
  always_comb begin
    hold_decode = ~flush & (ex_stall | hazard);
    do_bubble   = ~flush & ~ex_stall & hazard;
    do_advance  = ~flush & ~ex_stall & ~hazard;
  end

  // EX-side pipeline register; flush kills only the control, a bubble also zeroes data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid     <= 1'b0;
      e_rsrc      <= '0;
      e_rdst      <= '0;
      e_src       <= '0;
      e_dst       <= '0;
      e_wa        <= '0;
      e_reg_write <= 1'b0;
      e_mem_read  <= 1'b0;
      e_ctrl      <= '0;
      e_imm       <= '0;
    end else if (flush) begin
      e_valid     <= 1'b0;
      e_reg_write <= 1'b0;
      e_mem_read  <= 1'b0;
      e_ctrl      <= '0;
    end else if (do_bubble) begin
      e_valid     <= 1'b0;
      e_rsrc      <= '0;
      e_rdst      <= '0;
      e_src       <= '0;
      e_dst       <= '0;
      e_wa        <= '0;
      e_reg_write <= 1'b0;
      e_mem_read  <= 1'b0;
      e_ctrl      <= '0;
      e_imm       <= '0;
    end else if (do_advance) begin
      e_valid     <= d_valid;
      e_rsrc      <= fwd_rsrc;
      e_rdst      <= fwd_rdst;
      e_src       <= d_src;
      e_dst       <= d_dst;
      e_wa        <= d_wa;
      e_reg_write <= d_reg_write;
      e_mem_read  <= d_mem_read;
      e_ctrl      <= d_ctrl;
      e_imm       <= d_imm;
    end
  end

  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (do_bubble && (stall_count != CNT_MAX))
      stall_count <= stall_count + CNT_ONE;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, d_use_src, d_use_dst, d_reg_write, d_mem_read;
  logic [2:0]  d_src, d_dst, d_wa;
  logic [15:0] d_rsrc, d_rdst, d_imm;
  logic [7:0]  d_ctrl;
  logic        flush, ex_stall, wb_reg_write;
  logic [2:0]  wb_wa;
  logic [15:0] wb_wd;

  logic        hold_decode, e_valid, e_reg_write, e_mem_read;
  logic [15:0] e_rsrc, e_rdst, e_imm, stall_count;
  logic [2:0]  e_src, e_dst, e_wa;
  logic [7:0]  e_ctrl;

  logic        s_hold_decode, s_e_valid, s_e_reg_write, s_e_mem_read;
  logic [3:0]  s_e_rsrc, s_e_rdst, s_e_imm, s_stall_count;
  logic [2:0]  s_e_src, s_e_dst, s_e_wa;
  logic [7:0]  s_e_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(.W(16), .N(3), .CW(8)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_src(d_src), .d_dst(d_dst),
    .d_use_src(d_use_src), .d_use_dst(d_use_dst), .d_rsrc(d_rsrc), .d_rdst(d_rdst),
    .d_wa(d_wa), .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_ctrl(d_ctrl),
    .d_imm(d_imm), .flush(flush), .ex_stall(ex_stall), .wb_reg_write(wb_reg_write),
    .wb_wa(wb_wa), .wb_wd(wb_wd), .hold_decode(hold_decode), .e_valid(e_valid),
    .e_rsrc(e_rsrc), .e_rdst(e_rdst), .e_src(e_src), .e_dst(e_dst), .e_wa(e_wa),
    .e_reg_write(e_reg_write), .e_mem_read(e_mem_read), .e_ctrl(e_ctrl),
    .e_imm(e_imm), .stall_count(stall_count)
  );

  // Narrow-data copy so counter saturation is reachable in a short run
  id_ex_stage #(.W(4), .N(3), .CW(8)) dut_small (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_src(d_src), .d_dst(d_dst),
    .d_use_src(d_use_src), .d_use_dst(d_use_dst), .d_rsrc(d_rsrc[3:0]), .d_rdst(d_rdst[3:0]),
    .d_wa(d_wa), .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_ctrl(d_ctrl),
    .d_imm(d_imm[3:0]), .flush(flush), .ex_stall(ex_stall), .wb_reg_write(wb_reg_write),
    .wb_wa(wb_wa), .wb_wd(wb_wd[3:0]), .hold_decode(s_hold_decode), .e_valid(s_e_valid),
    .e_rsrc(s_e_rsrc), .e_rdst(s_e_rdst), .e_src(s_e_src), .e_dst(s_e_dst), .e_wa(s_e_wa),
    .e_reg_write(s_e_reg_write), .e_mem_read(s_e_mem_read), .e_ctrl(s_e_ctrl),
    .e_imm(s_e_imm), .stall_count(s_stall_count)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] rsrc;
    logic [15:0] rdst;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [2:0]  wa;
    logic        rw;
    logic        mr;
    logic [7:0]  ctrl;
    logic [15:0] imm;
  } ex_t;

  typedef struct packed {
    ex_t         e;
    logic [15:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  exp_t  exp_q[$];
  ex_t   m;
  logic  m_bubble;
  int    m_cnt;
  int    m_scnt;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m        = '0;
    m_bubble = 1'b0;
    m_cnt    = 0;
    m_scnt   = 0;
    exp_q.delete();
  endtask

  task automatic instr(input logic v, input logic [2:0] src, input logic [2:0] dst,
                       input logic us, input logic ud, input logic [15:0] rsrc,
                       input logic [15:0] rdst, input logic [2:0] wa, input logic rw,
                       input logic mr, input logic [7:0] ctrl, input logic [15:0] imm);
    d_valid = v; d_src = src; d_dst = dst; d_use_src = us; d_use_dst = ud;
    d_rsrc = rsrc; d_rdst = rdst; d_wa = wa; d_reg_write = rw; d_mem_read = mr;
    d_ctrl = ctrl; d_imm = imm;
  endtask

  task automatic ctl(input logic f, input logic s);
    flush = f; ex_stall = s;
  endtask

  task automatic compare_out();
    exp_t x;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    check("e_valid",     e_valid,       x.e.v);
    check("e_rsrc",      e_rsrc,        x.e.rsrc);
    check("e_rdst",      e_rdst,        x.e.rdst);
    check("e_src",       e_src,         x.e.src);
    check("e_dst",       e_dst,         x.e.dst);
    check("e_wa",        e_wa,          x.e.wa);
    check("e_reg_write", e_reg_write,   x.e.rw);
    check("e_mem_read",  e_mem_read,    x.e.mr);
    check("e_ctrl",      e_ctrl,        x.e.ctrl);
    check("e_imm",       e_imm,         x.e.imm);
    check("stall_count", stall_count,   x.cnt);
    check("stall_small", s_stall_count, x.scnt);
  endtask

  // Called just after a negedge with inputs set; checks hold_decode, predicts the edge, compares after it
  task automatic step();
    logic haz;
    exp_t x;
    #1;
    haz = d_valid && m.v && m.mr && m.rw && !m_bubble &&
          ((d_use_src && d_src == m.wa) || (d_use_dst && d_dst == m.wa));
    check("hold_decode", hold_decode, !flush && (ex_stall || haz));
    if (flush) begin
      m.v = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.ctrl = '0;
      m_bubble = 1'b0;
    end else if (ex_stall) begin
      // everything frozen
    end else if (haz) begin
      m = '0;
      m_bubble = 1'b1;
      if (m_cnt  < 65535) m_cnt++;
      if (m_scnt < 15)    m_scnt++;
    end else begin
      m.v    = d_valid;
      m.rsrc = (wb_reg_write && wb_wa == d_src) ? wb_wd : d_rsrc;
      m.rdst = (wb_reg_write && wb_wa == d_dst) ? wb_wd : d_rdst;
      m.src  = d_src;  m.dst = d_dst;  m.wa = d_wa;
      m.rw   = d_reg_write; m.mr = d_mem_read;
      m.ctrl = d_ctrl; m.imm = d_imm;
      m_bubble = 1'b0;
    end
    x.e = m; x.cnt = m_cnt[15:0]; x.scnt = m_scnt[3:0];
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ctl(1'b0, 1'b1);
    instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 3'd4, 1'b1, 1'b1, 8'hFF, 16'h7777);
    wb_reg_write = 1'b0; wb_wa = '0; wb_wd = '0;
    model_reset();
    #2;
    check("rst_e_valid",     e_valid, 0);
    check("rst_e_rsrc",      e_rsrc, 0);
    check("rst_e_ctrl",      e_ctrl, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_hold_decode", hold_decode, 1);
    @(negedge clk);
    rst = 1'b0;
    ctl(1'b0, 1'b0);

    // advance
    instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 16'h1234, 16'h0000, 3'd6, 1'b1, 1'b0, 8'h11, 16'h0005);
    step();
    check("t2_e_rsrc", e_rsrc, 16'h1234);
    check("t2_e_imm",  e_imm,  16'h0005);

    // load-use: one bubble then the dependent instruction enters
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0002, 3'd3, 1'b1, 1'b1, 8'h22, 16'h0010);
    step();
    instr(1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 16'h00C3, 16'h00D1, 3'd7, 1'b1, 1'b0, 8'h33, 16'h0020);
    step();
    check("t3_bubble_valid", e_valid, 0);
    check("t3_count",        stall_count, 1);
    step();
    check("t3_enter_valid",  e_valid, 1);

    // bypass of same-cycle writeback into e_rdst
    wb_reg_write = 1'b1; wb_wa = 3'd5; wb_wd = 16'hBEEF;
    instr(1'b1, 3'd1, 3'd5, 1'b0, 1'b1, 16'h0101, 16'h0000, 3'd2, 1'b1, 1'b0, 8'h44, 16'h0030);
    step();
    check("t4_e_rdst", e_rdst, 16'hBEEF);
    wb_reg_write = 1'b0;

    // priority: flush beats stall and hazard
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0002, 3'd3, 1'b1, 1'b1, 8'h55, 16'h0040);
    step();
    instr(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 16'h0E0E, 16'h0F0F, 3'd1, 1'b1, 1'b0, 8'h66, 16'h0050);
    ctl(1'b1, 1'b1);
    step();
    check("t5_valid", e_valid, 0);
    check("t5_count", stall_count, 1);
    ctl(1'b0, 1'b0);
    step();

    // stall hold over three cycles with changing decode inputs
    for (int i = 0; i < 3; i++) begin
      ctl(1'b0, 1'b1);
      instr(1'b1, 3'(i), 3'(i+1), 1'b1, 1'b1, 16'(i*7), 16'(i*9), 3'(i), 1'b1, 1'b1, 8'(i), 16'(i));
      step();
    end
    ctl(1'b0, 1'b0);

    // stall while a bubble is in flight: still only one bubble
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0002, 3'd4, 1'b1, 1'b1, 8'h77, 16'h0060);
    step();
    instr(1'b1, 3'd1, 3'd4, 1'b0, 1'b1, 16'h4444, 16'h4545, 3'd5, 1'b0, 1'b0, 8'h88, 16'h0070);
    step();
    ctl(1'b0, 1'b1); step(); step();
    ctl(1'b0, 1'b0); step();
    check("bubble_stall_valid", e_valid, 1);
    check("bubble_stall_count", stall_count, 2);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      ctl(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      instr($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), 16'($urandom));
      wb_reg_write = 1'($urandom); wb_wa = 3'($urandom_range(0, 7)); wb_wd = 16'($urandom);
      step();
    end
    wb_reg_write = 1'b0;
    ctl(1'b0, 1'b0);

    // asynchronous reset right after a bubble
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0002, 3'd3, 1'b1, 1'b1, 8'h99, 16'h0080);
    step();
    instr(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 16'h3333, 16'h0000, 3'd1, 1'b1, 1'b0, 8'hAA, 16'h0090);
    step();
    rst = 1'b1;
    #1;
    check("async_rst_valid", e_valid, 0);
    check("async_rst_wa",    e_wa, 0);
    check("async_rst_count", stall_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_no_bubble", e_valid, 1);

    // saturation of the narrow counter
    for (int i = 0; i < 20; i++) begin
      instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0002, 3'd2, 1'b1, 1'b1, 8'h01, 16'h0001);
      step();
      instr(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 16'h0002, 16'h0003, 3'd6, 1'b1, 1'b0, 8'h02, 16'h0002);
      step();
      step();
    end
    check("sat_small", s_stall_count, 15);
    check("sat_wide",  stall_count, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
